shifter_iter: RTL

- Parametrised, multi-cycle successor to the ALU's combinational 32-bit shifter.
- Shifts a WIDTH-bit operand by up to STEP bit positions per clock.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right.
- Uses a valid/ready handshake on both input and output, so it can be placed between the decode stage and writeback of the multi-cycle CPU datapath without a wide single-cycle barrel network.

---
 rtl/shifter_iter_if.sv | 26 ++
 rtl/shifter_iter.sv | 113 +++++++++++
 2 files changed

// File: rtl/shifter_iter_if.sv
// Request/result handshake bundle for the iterative shifter.
// The master side drives requests and consumes results.
interface shifter_iter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/shifter_iter.sv
// Multi-cycle shifter: moves the operand at most STEP bits per clock.
// Supports SLL/SRL/SRA/ROL/ROR behind valid/ready on both sides.
module shifter_iter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  shifter_iter_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [2:0] M_SLL = 3'b000;
  localparam logic [2:0] M_SRL = 3'b001;
  localparam logic [2:0] M_SRA = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;

  localparam logic [AW:0] STEP_C = (AW+1)'(STEP);
  localparam logic [AW:0] WIDTH_C = (AW+1)'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic             err_q, err_d;

  logic [AW-1:0]    s;
  logic [AW:0]      s_inv;
  logic [WIDTH-1:0] stepped;
  logic             in_bad;

  assign in_bad = io.in_mode[2] & (|io.in_mode[1:0]);

  // s never exceeds STEP, so only a narrow shift is taken per clock
  assign s     = ({1'b0, rem_q} > STEP_C) ? STEP_C[AW-1:0] : rem_q;
  assign s_inv = WIDTH_C - {1'b0, s};

  always_comb begin
    stepped = data_q;
    case (mode_q)
      M_SLL:   stepped = data_q << s;
      M_SRL:   stepped = data_q >> s;
      M_SRA:   stepped = WIDTH'($signed(data_q) >>> s);
      M_ROL:   stepped = (data_q << s) | (data_q >> s_inv);
      M_ROR:   stepped = (data_q >> s) | (data_q << s_inv);
      default: stepped = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          data_d = io.in_data;
          rem_d  = io.in_amt;
          mode_d = io.in_mode;
          err_d  = in_bad;
          if (in_bad || io.in_amt == '0)
            state_d = DONE;
          else
            state_d = BUSY;
        end
      end
      BUSY: begin
        data_d = stepped;
        rem_d  = rem_q - s;
        if (rem_q == s)
          state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = data_q;
  assign io.out_err   = err_q;

endmodule
